// File: rtl/wavetable_osc_mc.sv
// wavetable_osc_mc: round-robin multi-channel oscillator with a shared
// quarter-wave sine ROM and per-channel sine/saw/square/triangle mode.
module wavetable_osc_mc #(
  parameter int CHANNELS   = 4,
  parameter int PHASE_W    = 32,
  parameter int ADDR_W     = 10,
  parameter int OUT_W      = 16,
  parameter     TABLE_FILE = "SINE_QTR.mem",
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         LOCKED,
  input  logic [CHANNELS*PHASE_W-1:0]  CH_FREQ,
  input  logic [CHANNELS*2-1:0]        CH_MODE,
  input  logic [CHANNELS-1:0]          CH_SYNC,
  output logic [OUT_W-1:0]             SAMPLE_OUT,
  output logic [CW-1:0]                SAMPLE_CH,
  output logic                         SAMPLE_VALID
);

  typedef enum logic [1:0] {
    M_SINE, M_SAW, M_SQR, M_TRI
  } mode_e;

  localparam int KW =
    (OUT_W + 1 > ADDR_W + 2) ? OUT_W + 1 : ADDR_W + 2;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [OUT_W-1:0] AMP =
    {1'b0, {(OUT_W-1){1'b1}}};

  // Table image is computed at elaboration (Taylor series, rounded)
  function automatic logic [OUT_W-1:0] sin_entry(input int k);
    real x, x2, term, acc;
    int  v;
    x    = $itor(2 * k + 1) * 3.14159265358979323846
           / $itor(2 ** (ADDR_W + 2));
    x2   = x * x;
    term = x;
    acc  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x2 / $itor((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    v = $rtoi($itor(2 ** (OUT_W - 1) - 1) * acc + 0.5);
    return v[OUT_W-1:0];
  endfunction

  logic [OUT_W-1:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic [OUT_W-1:0] V = sin_entry(k);
    assign rom[k] = V;
  end

  logic [CW-1:0]       ch, ch_nxt;
  logic [PHASE_W-1:0]  phase [CHANNELS];
  logic [CHANNELS-1:0] pend, svc;
  logic [PHASE_W-1:0]  p0, inc;
  logic                sync_now;
  mode_e               mode0;

  logic                s1_v;
  logic [KW-1:0]       s1_p;
  logic [CW-1:0]       s1_c;
  mode_e               s1_m;
  logic [ADDR_W-1:0]   s1_i, addr;

  logic                s2_v;
  logic [OUT_W:0]      s2_p;
  logic [CW-1:0]       s2_c;
  mode_e               s2_m;
  logic [OUT_W-1:0]    rom_q;

  logic                out_v;
  logic                m;
  logic [OUT_W-1:0]    t, u, y;

  always_comb begin
    svc      = '0;
    svc[ch]  = LOCKED;
    inc      = CH_FREQ[ch*PHASE_W +: PHASE_W];
    mode0    = mode_e'(CH_MODE[ch*2 +: 2]);
    sync_now = pend[ch] | CH_SYNC[ch];
    p0       = sync_now ? '0 : phase[ch];
    ch_nxt   = (ch == CW'(CHANNELS - 1)) ? '0 : ch + 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ch   <= '0;
      pend <= '0;
      for (int k = 0; k < CHANNELS; k++) phase[k] <= '0;
      s1_v <= 1'b0;
      s1_p <= '0;
      s1_c <= '0;
      s1_m <= M_SINE;
    end else begin
      // pending syncs keep accumulating even while stalled
      pend <= (pend | CH_SYNC) & ~svc;
      if (LOCKED) begin
        ch        <= ch_nxt;
        phase[ch] <= p0 + inc;
        s1_v      <= 1'b1;
        s1_p      <= p0[PHASE_W-1 -: KW];
        s1_c      <= ch;
        s1_m      <= mode0;
      end
    end
  end

  assign s1_i = s1_p[KW-3 -: ADDR_W];
  assign addr = s1_p[KW-2] ? ~s1_i : s1_i;

  // ROM data register left without reset so it maps onto block RAM
  always_ff @(posedge CLK) begin
    if (LOCKED) rom_q <= rom[addr];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s2_v <= 1'b0;
      s2_p <= '0;
      s2_c <= '0;
      s2_m <= M_SINE;
    end else if (LOCKED) begin
      s2_v <= s1_v;
      s2_p <= s1_p[KW-1 -: OUT_W+1];
      s2_c <= s1_c;
      s2_m <= s1_m;
    end
  end

  assign m = s2_p[OUT_W];
  assign t = s2_p[OUT_W-1:0];
  assign u = m ? ~t : t;

  always_comb begin
    y = '0;
    unique case (s2_m)
      M_SINE: y = m ? -rom_q : rom_q;
      M_SAW:  y = {~m, s2_p[OUT_W-1 -: OUT_W-1]};
      M_SQR:  y = m ? -AMP : AMP;
      M_TRI:  y = {~u[OUT_W-1], u[OUT_W-2:0]};
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_v      <= 1'b0;
      SAMPLE_OUT <= '0;
      SAMPLE_CH  <= '0;
    end else if (LOCKED) begin
      out_v <= s2_v;
      if (s2_v) begin
        SAMPLE_OUT <= y;
        SAMPLE_CH  <= s2_c;
      end
    end
  end

  assign SAMPLE_VALID = out_v & LOCKED;

endmodule

// File: tb/tb_wavetable_osc_mc.sv
// tb_wavetable_osc_mc: randomized bench for wavetable_osc_mc against a
// per-channel phase/waveform reference model.
module tb_wavetable_osc_mc;

  localparam int NC = 4;
  localparam real PI = 3.14159265358979323846;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          LOCKED = 1'b0;
  logic [NC*32-1:0] CH_FREQ = '0;
  logic [NC*2-1:0]  CH_MODE = '0;
  logic [NC-1:0]    CH_SYNC = '0;
  logic [15:0]   SAMPLE_OUT;
  logic [1:0]    SAMPLE_CH;
  logic          SAMPLE_VALID;

  int n_run  = 0;
  int n_fail = 0;

  wavetable_osc_mc #(
    .CHANNELS(NC), .PHASE_W(32), .ADDR_W(10), .OUT_W(16)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .LOCKED(LOCKED),
    .CH_FREQ(CH_FREQ),
    .CH_MODE(CH_MODE),
    .CH_SYNC(CH_SYNC),
    .SAMPLE_OUT(SAMPLE_OUT),
    .SAMPLE_CH(SAMPLE_CH),
    .SAMPLE_VALID(SAMPLE_VALID)
  );

  always #5 CLK = ~CLK;

  // reference model: phase per channel, pending syncs, output queue
  bit [31:0]   mph [NC];
  bit          mpend [NC];
  int          mcnt;
  logic [15:0] qv [$];
  int          qc [$];
  logic [15:0] last_v;
  int          last_c;

  function automatic logic [15:0] ref_sample(input bit [31:0] p,
                                             input bit [1:0] md);
    int q, i, idx, a, v;
    bit [31:0] t;
    v = 0;
    case (md)
      2'd0: begin
        q   = int'(p >> 30);
        i   = int'((p >> 20) & 32'd1023);
        idx = (q % 2 == 1) ? 1023 - i : i;
        a   = $rtoi(32767.0 * $sin(($itor(idx) + 0.5) * PI / 2048.0) + 0.5);
        v   = (q >= 2) ? -a : a;
      end
      2'd1: v = int'(p >> 16) - 32768;
      2'd2: v = (p < 32'h8000_0000) ? 32767 : -32767;
      default: begin
        t = (p >> 15) & 32'hFFFF;
        v = (p >= 32'h8000_0000) ? 65535 - int'(t) : int'(t);
        v = v - 32768;
      end
    endcase
    return v[15:0];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      mph[c]   = '0;
      mpend[c] = 1'b0;
    end
    mcnt   = 0;
    qv.delete();
    qc.delete();
    last_v = '0;
    last_c = 0;
  endtask

  task automatic apply_reset();
    RESET_N = 1'b0;
    LOCKED  = 1'b1;
    CH_SYNC = '0;
    @(negedge CLK);
    @(negedge CLK);
    model_reset();
    RESET_N = 1'b1;
  endtask

  // one clock: drive, advance model at the edge, return expected outputs
  task automatic step(input bit lk, input bit [NC-1:0] sy,
                      output bit ev, output logic [15:0] eo,
                      output int ec);
    bit [31:0] p;
    LOCKED  = lk;
    CH_SYNC = sy;
    @(posedge CLK);
    ev = 1'b0;
    if (lk) begin
      p = (mpend[mcnt] || sy[mcnt]) ? 32'd0 : mph[mcnt];
      mph[mcnt] = p + CH_FREQ[mcnt*32 +: 32];
      qv.push_back(ref_sample(p, CH_MODE[mcnt*2 +: 2]));
      qc.push_back(mcnt);
    end
    for (int c = 0; c < NC; c++) mpend[c] = mpend[c] | sy[c];
    if (lk) begin
      mpend[mcnt] = 1'b0;
      mcnt = (mcnt + 1) % NC;
      if (qv.size() == 3) begin
        last_v = qv.pop_front();
        last_c = qc.pop_front();
        ev = 1'b1;
      end
    end
    eo = last_v;
    ec = last_c;
    @(negedge CLK);
  endtask

  task automatic randomize_channels();
    for (int c = 0; c < NC; c++) begin
      CH_FREQ[c*32 +: 32] = $urandom;
      CH_MODE[c*2 +: 2]   = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic test_reset();
    bit ev; logic [15:0] eo; int ec;
    randomize_channels();
    CH_MODE[1:0] = 2'd1;
    CH_FREQ[31:0] = 32'h0345_6789;
    apply_reset();
    for (int k = 0; k < 13; k++) step(1'b1, '0, ev, eo, ec);
    #2;
    RESET_N = 1'b0;
    #1;
    n_run += 3;
    if (SAMPLE_OUT !== 16'h0) begin
      n_fail++; $display("FAIL reset_out: got %h want 0000", SAMPLE_OUT);
    end
    if (SAMPLE_CH !== 2'd0) begin
      n_fail++; $display("FAIL reset_ch: got %0d want 0", SAMPLE_CH);
    end
    if (SAMPLE_VALID !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", SAMPLE_VALID);
    end
    @(negedge CLK);
    @(negedge CLK);
    model_reset();
    RESET_N = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, '0, ev, eo, ec);
      n_run++;
      if (SAMPLE_VALID !== (k == 3)) begin
        n_fail++;
        $display("FAIL reset_latency edge %0d: got %b want %b",
                 k, SAMPLE_VALID, k == 3);
      end
    end
    n_run += 2;
    if (SAMPLE_CH !== 2'd0) begin
      n_fail++; $display("FAIL reset_first_ch: got %0d want 0", SAMPLE_CH);
    end
    if (SAMPLE_OUT !== eo) begin
      n_fail++; $display("FAIL reset_first_out: got %h want %h", SAMPLE_OUT, eo);
    end
  endtask

  task automatic test_saw();
    bit ev; logic [15:0] eo; int ec;
    logic [15:0] w;
    int n0;
    randomize_channels();
    CH_MODE[1:0]  = 2'd1;
    CH_FREQ[31:0] = 32'h1000_0000;
    apply_reset();
    n0 = 0;
    for (int k = 0; k < 4 * 36; k++) begin
      step(1'b1, '0, ev, eo, ec);
      n_run++;
      if (SAMPLE_VALID !== ev || SAMPLE_OUT !== eo || SAMPLE_CH !== 2'(ec)) begin
        n_fail++;
        $display("FAIL saw_model step %0d: got v%b %h ch%0d want v%b %h ch%0d",
                 k, SAMPLE_VALID, SAMPLE_OUT, SAMPLE_CH, ev, eo, ec);
      end
      if (SAMPLE_VALID && SAMPLE_CH == 2'd0) begin
        w = 16'h8000 + 16'((n0 % 16) * 32'h1000);
        n_run++;
        if (SAMPLE_OUT !== w) begin
          n_fail++;
          $display("FAIL saw_seq n%0d: got %h want %h", n0, SAMPLE_OUT, w);
        end
        n0++;
      end
    end
  endtask

  task automatic test_sine();
    bit ev; logic [15:0] eo; int ec;
    int pk, peak, n1;
    randomize_channels();
    CH_MODE[3:2]   = 2'd0;
    CH_FREQ[63:32] = 32'h0400_0000;
    apply_reset();
    pk   = $rtoi(32767.0 * $sin(1023.5 * PI / 2048.0) + 0.5);
    peak = -40000;
    n1   = 0;
    for (int k = 0; k < 4 * 70; k++) begin
      step(1'b1, '0, ev, eo, ec);
      n_run++;
      if (SAMPLE_VALID !== ev || SAMPLE_OUT !== eo || SAMPLE_CH !== 2'(ec)) begin
        n_fail++;
        $display("FAIL sine_model step %0d: got v%b %h ch%0d want v%b %h ch%0d",
                 k, SAMPLE_VALID, SAMPLE_OUT, SAMPLE_CH, ev, eo, ec);
      end
      if (SAMPLE_VALID && SAMPLE_CH == 2'd1 && n1 < 64) begin
        if (int'($signed(SAMPLE_OUT)) > peak) peak = int'($signed(SAMPLE_OUT));
        n1++;
      end
    end
    n_run++;
    if (peak !== pk) begin
      n_fail++; $display("FAIL sine_peak: got %0d want %0d", peak, pk);
    end
  endtask

  task automatic test_square_tri();
    bit ev; logic [15:0] eo; int ec;
    logic [15:0] w;
    int n2;
    randomize_channels();
    CH_MODE[5:4]   = 2'd2;
    CH_FREQ[95:64] = 32'h4000_0000;
    CH_MODE[7:6]   = 2'd3;
    CH_FREQ[127:96] = 32'h0B00_0000 | 32'($urandom_range(0, 32'hFFFFF));
    apply_reset();
    n2 = 0;
    for (int k = 0; k < 4 * 40; k++) begin
      step(1'b1, '0, ev, eo, ec);
      n_run++;
      if (SAMPLE_VALID !== ev || SAMPLE_OUT !== eo || SAMPLE_CH !== 2'(ec)) begin
        n_fail++;
        $display("FAIL sqtri_model step %0d: got v%b %h ch%0d want v%b %h ch%0d",
                 k, SAMPLE_VALID, SAMPLE_OUT, SAMPLE_CH, ev, eo, ec);
      end
      if (SAMPLE_VALID && SAMPLE_CH == 2'd2 && n2 < 8) begin
        w = (n2 % 4 < 2) ? 16'h7FFF : 16'h8001;
        n_run++;
        if (SAMPLE_OUT !== w) begin
          n_fail++;
          $display("FAIL square_seq n%0d: got %h want %h", n2, SAMPLE_OUT, w);
        end
        n2++;
      end
    end
  endtask

  // pulse CH_SYNC[3] in a given slot (or while stalled) and check the
  // n-th following ch3 sample is the saw value at phase 0
  task automatic sync_case(input int slot, input bit stalled,
                           input int nth, input string nm);
    bit ev; logic [15:0] eo; int ec;
    int seen, guard;
    bit got;
    guard = 0;
    while (mcnt != slot && guard < 8) begin
      step(1'b1, '0, ev, eo, ec);
      guard++;
    end
    if (stalled) begin
      step(1'b0, '0, ev, eo, ec);
      step(1'b0, 4'b1000, ev, eo, ec);
      step(1'b0, '0, ev, eo, ec);
    end else begin
      step(1'b1, 4'b1000, ev, eo, ec);
    end
    seen = 0;
    got  = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      step(1'b1, '0, ev, eo, ec);
      n_run++;
      if (SAMPLE_VALID !== ev || SAMPLE_OUT !== eo || SAMPLE_CH !== 2'(ec)) begin
        n_fail++;
        $display("FAIL %s_model step %0d: got v%b %h ch%0d want v%b %h ch%0d",
                 nm, k, SAMPLE_VALID, SAMPLE_OUT, SAMPLE_CH, ev, eo, ec);
      end
      if (SAMPLE_VALID && SAMPLE_CH == 2'd3) begin
        seen++;
        if (seen == nth) begin
          got = 1'b1;
          n_run++;
          if (SAMPLE_OUT !== 16'h8000) begin
            n_fail++;
            $display("FAIL %s: got %h want 8000", nm, SAMPLE_OUT);
          end
        end
      end
    end
    if (!got) begin
      n_run++; n_fail++;
      $display("FAIL %s_timeout: got no ch3 sample want one", nm);
    end
  endtask

  task automatic test_sync();
    bit ev; logic [15:0] eo; int ec;
    randomize_channels();
    CH_MODE = {NC{2'd1}};
    CH_FREQ[127:96] = 32'h0123_4567;
    apply_reset();
    for (int k = 0; k < 21; k++) step(1'b1, '0, ev, eo, ec);
    sync_case(1, 1'b0, 1, "sync_slot1");
    for (int k = 0; k < 9; k++) step(1'b1, '0, ev, eo, ec);
    sync_case(3, 1'b0, 1, "sync_own_slot");
    for (int k = 0; k < 9; k++) step(1'b1, '0, ev, eo, ec);
    sync_case(0, 1'b1, 2, "sync_stalled");
  endtask

  task automatic test_stall();
    bit ev; logic [15:0] eo; int ec;
    randomize_channels();
    apply_reset();
    for (int k = 0; k < 30 + 7 + 30; k++) begin
      step(!(k >= 30 && k < 37), '0, ev, eo, ec);
      n_run++;
      if (SAMPLE_VALID !== ev || SAMPLE_OUT !== eo || SAMPLE_CH !== 2'(ec)) begin
        n_fail++;
        $display("FAIL stall step %0d: got v%b %h ch%0d want v%b %h ch%0d",
                 k, SAMPLE_VALID, SAMPLE_OUT, SAMPLE_CH, ev, eo, ec);
      end
    end
  endtask

  task automatic test_random();
    bit ev; logic [15:0] eo; int ec;
    bit lk;
    bit [NC-1:0] sy;
    int c;
    randomize_channels();
    apply_reset();
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 49) == 0) begin
        c = $urandom_range(0, NC - 1);
        CH_FREQ[c*32 +: 32] = $urandom;
        CH_MODE[c*2 +: 2]   = 2'($urandom_range(0, 3));
      end
      lk = ($urandom_range(0, 9) != 0);
      sy = ($urandom_range(0, 19) == 0) ? NC'($urandom) : '0;
      step(lk, sy, ev, eo, ec);
      n_run++;
      if (SAMPLE_VALID !== ev || SAMPLE_OUT !== eo || SAMPLE_CH !== 2'(ec)) begin
        n_fail++;
        $display("FAIL random step %0d: got v%b %h ch%0d want v%b %h ch%0d",
                 k, SAMPLE_VALID, SAMPLE_OUT, SAMPLE_CH, ev, eo, ec);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ev; logic [15:0] eo; int ec;
    randomize_channels();
    CH_FREQ[31:0] = 32'h0;
    apply_reset();
    for (int k = 0; k < 4 * 12; k++) begin
      if (k == 20) randomize_channels();
      step(1'b1, '0, ev, eo, ec);
      n_run++;
      if (SAMPLE_VALID !== ev || SAMPLE_OUT !== eo || SAMPLE_CH !== 2'(ec)) begin
        n_fail++;
        $display("FAIL b2b step %0d: got v%b %h ch%0d want v%b %h ch%0d",
                 k, SAMPLE_VALID, SAMPLE_OUT, SAMPLE_CH, ev, eo, ec);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_saw();
    test_sine();
    test_square_tri();
    test_sync();
    test_stall();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
